// File: rtl/ysyx_axi4_sram_slave_pkg.sv
// Shared encodings and address-advance helper for the AXI4 SRAM responder.
package ysyx_axi4_sram_slave_pkg;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [2:0]  size,
                                                input logic [1:0]  burst);
    return (burst == BURST_INCR) ? addr + (64'd1 << size) : addr;
  endfunction

endpackage

// File: rtl/ysyx_axi4_burst_addr.sv
// Registered burst beat counter and address generator (one per AXI channel).
module ysyx_axi4_burst_addr
  import ysyx_axi4_sram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        beat_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_q;
  logic [ADDR_W-1:0] next_addr;

  assign next_addr = ADDR_W'(axi_next_addr(64'(addr_q), size_q, burst_q));
  assign addr_o    = addr_q;
  assign beat_o    = beat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
    end else if (load_i) begin
      addr_q  <= addr_i;
      size_q  <= size_i;
      burst_q <= burst_i;
      beat_q  <= '0;
    end else if (adv_i) begin
      addr_q  <= next_addr;
      beat_q  <= beat_q + 8'd1;
    end
  end

endmodule

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 SRAM responder with independent read/write FSMs, FIXED/INCR bursts.
// Optional ready throttling: define YSYX_AXI_SLAVE_RAND_DELAY_EN.
module ysyx_axi4_sram_slave
  import ysyx_axi4_sram_slave_pkg::*;
#(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 64,
  parameter int unsigned       DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000),
  parameter int unsigned       RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arsize,
  input  logic [7:0]          arlen,
  input  logic [3:0]          arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready_o,
  output logic [3:0]          rid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rlast_o,
  output logic                rvalid_o,
  input  logic                rready,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awsize,
  input  logic [7:0]          awlen,
  input  logic [3:0]          awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready_o,
  output logic [3:0]          bid_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> 3);
  endfunction

  logic gate;
`ifdef YSYX_AXI_SLAVE_RAND_DELAY_EN
  logic [19:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 20'd1;
    else     lfsr_q <= {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[18]};
  end
  assign gate = lfsr_q[19];
`else
  assign gate = 1'b1;
`endif

  // ---------------- read channel ----------------
  rd_state_e         rd_state_q;
  logic              arready_q, rvalid_q, rlast_q, rd_err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic [3:0]        rid_q;
  logic [7:0]        rd_len_q, rd_cnt_q, rd_beat;
  logic [ADDR_W-1:0] rd_addr;
  logic              ar_hs, r_hs, rd_fetch, rd_beat_err;

  assign arready_o = arready_q & gate;
  assign rvalid_o  = rvalid_q;
  assign rlast_o   = rlast_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rid_o     = rid_q;

  assign ar_hs = arvalid & arready_o;
  assign r_hs  = rvalid_q & rready;
  // The read generator holds the address of the next beat to fetch, so it
  // advances when a beat is loaded into the output register.
  assign rd_fetch = ((rd_state_q == R_WAIT) && (rd_cnt_q == '0)) ||
                    ((rd_state_q == R_BURST) && r_hs && !rlast_q);
  assign rd_beat_err = rd_err_q || !in_range(rd_addr);

  ysyx_axi4_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ar_hs),
    .adv_i   (rd_fetch),
    .addr_i  (araddr),
    .size_i  (arsize),
    .burst_i (arburst),
    .addr_o  (rd_addr),
    .beat_o  (rd_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rid_q      <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      if (rd_fetch) begin
        rvalid_q <= 1'b1;
        rlast_q  <= (rd_beat == rd_len_q);
        rdata_q  <= rd_beat_err ? '0 : mem[word_idx(rd_addr)];
        rresp_q  <= rd_beat_err ? RESP_SLVERR : RESP_OKAY;
      end
      case (rd_state_q)
        R_IDLE: if (ar_hs) begin
          rid_q      <= arid;
          rd_len_q   <= arlen;
          rd_err_q   <= !in_range(araddr) || (arsize > 3'd3) || (arburst == BURST_WRAP);
          rd_cnt_q   <= 8'(RD_LAT - 1);
          arready_q  <= 1'b0;
          rd_state_q <= R_WAIT;
        end
        R_WAIT: begin
          if (rd_cnt_q == '0) rd_state_q <= R_BURST;
          else                rd_cnt_q   <= rd_cnt_q - 8'd1;
        end
        R_BURST: if (r_hs && rlast_q) begin
          rvalid_q   <= 1'b0;
          rlast_q    <= 1'b0;
          arready_q  <= 1'b1;
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  wr_state_e         wr_state_q;
  logic              awready_q, wready_q, bvalid_q, wr_err_q;
  logic [1:0]        bresp_q;
  logic [3:0]        bid_q;
  logic [7:0]        wr_len_q, wr_beat;
  logic [ADDR_W-1:0] wr_addr;
  logic              aw_hs, w_hs, wr_beat_err, wr_cnt_last, mem_we;

  assign awready_o = awready_q & gate;
  assign wready_o  = wready_q & gate;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;
  assign bid_o     = bid_q;

  assign aw_hs       = awvalid & awready_o;
  assign w_hs        = wvalid & wready_o;
  assign wr_beat_err = wr_err_q || !in_range(wr_addr);
  assign wr_cnt_last = (wr_beat == wr_len_q);
  assign mem_we      = w_hs && !wr_beat_err;

  ysyx_axi4_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (aw_hs),
    .adv_i   (w_hs),
    .addr_i  (awaddr),
    .size_i  (awsize),
    .burst_i (awburst),
    .addr_o  (wr_addr),
    .beat_o  (wr_beat)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx(wr_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bid_q      <= '0;
      wr_len_q   <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        W_IDLE: if (aw_hs) begin
          bid_q      <= awid;
          wr_len_q   <= awlen;
          wr_err_q   <= !in_range(awaddr) || (awsize > 3'd3) || (awburst == BURST_WRAP);
          awready_q  <= 1'b0;
          wready_q   <= 1'b1;
          wr_state_q <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          if (wr_beat_err) wr_err_q <= 1'b1;
          // Whichever of wlast or the beat count comes first ends the burst.
          if (wlast || wr_cnt_last) begin
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= (wr_beat_err || (wlast != wr_cnt_last)) ? RESP_SLVERR : RESP_OKAY;
            wr_state_q <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b1;
          wr_state_q <= W_IDLE;
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

endmodule
